// File: rtl/axi_rdata_sender.sv
// axi_rdata_sender: drains one read burst per accepted command from a
// fall-through source FIFO onto an AXI4 R channel (single output register).
// Optional feature: define RDATA_STARVE_TIMEOUT_EN to finish a burst with
// SLVERR beats when the FIFO stays empty for STARVE_LIMIT cycles.
module axi_rdata_sender #(
    parameter int W_DATA       = 32,
    parameter int W_ID         = 4,
    parameter int W_LEN        = 4,
    parameter int STARVE_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W_ID-1:0]   cmd_id,
    input  logic [W_LEN-1:0]  cmd_len,
    input  logic              fifo_empty,
    input  logic [W_DATA-1:0] fifo_rdata,
    output logic              fifo_en_read,
    output logic              m_rvalid,
    input  logic              m_rready,
    output logic [W_DATA-1:0] m_rdata,
    output logic [W_ID-1:0]   m_rid,
    output logic [1:0]        m_rresp,
    output logic              m_rlast,
    output logic              busy
);

    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;
    localparam logic [W_LEN:0] CNT_ONE     = {{W_LEN{1'b0}}, 1'b1};

    // The starvation counter is 8 bits wide, so the limit must fit in it.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_check
        $error("axi_rdata_sender: STARVE_LIMIT must be within 1..255");
    end

    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_next;

    logic [W_ID-1:0]  id_q;
    logic [W_LEN-1:0] len_q;
    logic [W_LEN:0]   load_cnt;  // beats pulled into the output register
    logic [W_LEN:0]   sent_cnt;  // beats accepted by the R channel

    logic cmd_take, beat_hs, burst_done, slot_free;
    logic load_real, load_fake, load_any;

    assign cmd_take  = cmd_valid && cmd_ready;
    assign beat_hs   = m_rvalid && m_rready;
    // The beat on the bus is beat number sent_cnt; the final one closes the burst.
    assign burst_done = beat_hs && (sent_cnt == {1'b0, len_q});
    // Output register is free (or freeing this edge) and beats remain to load.
    assign slot_free = (state == BURST) && (!m_rvalid || m_rready)
                       && (load_cnt <= {1'b0, len_q});

`ifdef RDATA_STARVE_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic       starved_q;
    logic       starved;

    // Once starved, every remaining beat is synthesised without touching the FIFO.
    assign starved   = starved_q || (starve_cnt == LIMIT);
    assign load_real = slot_free && !fifo_empty && !starved;
    assign load_fake = slot_free && starved;

    // Count consecutive cycles where a load waits only on an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            starved_q  <= 1'b0;
        end else if (state == IDLE) begin
            starve_cnt <= '0;
            starved_q  <= 1'b0;
        end else begin
            if (load_any)
                starve_cnt <= '0;
            else if (slot_free && fifo_empty && !starved)
                starve_cnt <= starve_cnt + 8'd1;
            if (load_fake)
                starved_q <= 1'b1;
        end
    end
`else
    assign load_real = slot_free && !fifo_empty;
    assign load_fake = 1'b0;
`endif

    assign load_any = load_real || load_fake;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next-state: accept in IDLE, return on the last handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_take)   state_next = BURST;
            BURST:   if (burst_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: command handshake, busy flag and FIFO pop strobe.
    always_comb begin
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        fifo_en_read = load_real;
        case (state)
            IDLE:    cmd_ready = !rst;
            BURST:   busy      = 1'b1;
            default: ;
        endcase
    end

    // Command latch and burst beat counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q     <= '0;
            len_q    <= '0;
            load_cnt <= '0;
            sent_cnt <= '0;
        end else if (cmd_take) begin
            id_q     <= cmd_id;
            len_q    <= cmd_len;
            load_cnt <= '0;
            sent_cnt <= '0;
        end else begin
            if (load_any)
                load_cnt <= load_cnt + CNT_ONE;
            if (beat_hs)
                sent_cnt <= sent_cnt + CNT_ONE;
        end
    end

    // R channel output register: load a beat, or drop valid after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rvalid <= 1'b0;
            m_rdata  <= '0;
            m_rid    <= '0;
            m_rresp  <= RESP_OKAY;
            m_rlast  <= 1'b0;
        end else if (load_any) begin
            m_rvalid <= 1'b1;
            m_rdata  <= load_fake ? '0 : fifo_rdata;
            m_rid    <= id_q;
            m_rresp  <= load_fake ? RESP_SLVERR : RESP_OKAY;
            m_rlast  <= (load_cnt == {1'b0, len_q});
        end else if (beat_hs) begin
            m_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_rdata_sender.sv
// Directed bench for axi_rdata_sender: a fall-through FIFO model feeds the
// DUT, a negedge monitor logs every R handshake and FIFO pop, and each task
// checks its own scenario against hand-computed values.
module tb_axi_rdata_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_id = 4'd0;
    logic [3:0]  cmd_len = 4'd0;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_en_read;
    logic        m_rvalid;
    logic        m_rready = 1'b0;
    logic [31:0] m_rdata;
    logic [3:0]  m_rid;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        busy;

    // FIFO model: written by the stimulus, popped at the clock edge.
    logic [31:0] mem [256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    // Monitor log.
    int          nb = 0;
    int          np = 0;
    int          bad_pop = 0;
    int          cyc = 0;
    logic [31:0] bdata [64];
    logic [3:0]  bid   [64];
    logic [1:0]  bresp [64];
    logic        blast [64];
    int          bcyc  [64];

    int checks = 0;
    int passed = 0;

    axi_rdata_sender #(
        .W_DATA(32), .W_ID(4), .W_LEN(4), .STARVE_LIMIT(10)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_len(cmd_len),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_en_read(fifo_en_read),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .busy(busy)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (fifo_en_read && !fifo_empty)
            rd_ptr <= rd_ptr + 1;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m_rvalid && m_rready && nb < 64) begin
            bdata[nb] <= m_rdata;
            bid[nb]   <= m_rid;
            bresp[nb] <= m_rresp;
            blast[nb] <= m_rlast;
            bcyc[nb]  <= cyc;
            nb        <= nb + 1;
        end
        if (fifo_en_read)
            np <= np + 1;
        if (fifo_en_read && fifo_empty)
            bad_pop <= bad_pop + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    // Offers a command and returns just after the accepting edge.
    task automatic send_cmd(input logic [3:0] id, input logic [3:0] len);
        tick();
        cmd_id = id; cmd_len = len; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (cmd_ready) break;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget);
        for (int i = 0; i < budget && nb < target; i++)
            sample();
    endtask

    task automatic test_reset();
        sample(); sample();
        checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); else passed++;
        checks++; if (m_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", m_rvalid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        checks++; if (fifo_en_read !== 1'b0) $display("FAIL rst_en_read: got %b want 0", fifo_en_read); else passed++;
        checks++; if (m_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", m_rdata); else passed++;
        checks++; if (m_rid !== 4'h0 || m_rresp !== 2'b00 || m_rlast !== 1'b0)
            $display("FAIL rst_rid_rresp_rlast: got %h/%b/%b want 0/00/0", m_rid, m_rresp, m_rlast); else passed++;
        tick();
        rst = 1'b0;
        sample();
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_cmd_ready: got %b want 1", cmd_ready); else passed++;
    endtask

    task automatic test_burst4();
        logic [31:0] exp_w [4];
        int b0, p0;
        exp_w = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004};
        flush();
        for (int k = 0; k < 4; k++) push(exp_w[k]);
        m_rready = 1'b1;
        b0 = nb; p0 = np;
        send_cmd(4'd5, 4'd3);
        sample();
        checks++; if (fifo_en_read !== 1'b1) $display("FAIL b4_first_pop: got %b want 1", fifo_en_read); else passed++;
        checks++; if (m_rvalid !== 1'b0) $display("FAIL b4_first_rvalid: got %b want 0", m_rvalid); else passed++;
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0)
            $display("FAIL b4_busy_ready: got %b/%b want 1/0", busy, cmd_ready); else passed++;
        wait_beats(b0 + 4, 30);
        checks++; if (nb - b0 !== 4) $display("FAIL b4_beats: got %0d want 4", nb - b0); else passed++;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bdata[b0+k] !== exp_w[k]) $display("FAIL b4_data%0d: got %h want %h", k, bdata[b0+k], exp_w[k]); else passed++;
            checks++; if (bid[b0+k] !== 4'd5) $display("FAIL b4_rid%0d: got %h want 5", k, bid[b0+k]); else passed++;
            checks++; if (blast[b0+k] !== (k == 3)) $display("FAIL b4_rlast%0d: got %b want %b", k, blast[b0+k], (k == 3)); else passed++;
            checks++; if (bresp[b0+k] !== 2'b00) $display("FAIL b4_rresp%0d: got %b want 00", k, bresp[b0+k]); else passed++;
        end
        checks++; if (bcyc[b0+3] - bcyc[b0] !== 3) $display("FAIL b4_throughput: got span %0d want 3", bcyc[b0+3] - bcyc[b0]); else passed++;
        checks++; if (np - p0 !== 4) $display("FAIL b4_pops: got %0d want 4", np - p0); else passed++;
        sample();
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || m_rvalid !== 1'b0)
            $display("FAIL b4_idle_after: got busy %b ready %b rvalid %b want 0 1 0", busy, cmd_ready, m_rvalid); else passed++;
    endtask

    task automatic test_len0();
        int b0, p0;
        flush();
        push(32'hA5A5_A5A5);
        m_rready = 1'b1;
        b0 = nb; p0 = np;
        send_cmd(4'd2, 4'd0);
        wait_beats(b0 + 1, 20);
        repeat (3) sample();
        checks++; if (nb - b0 !== 1) $display("FAIL len0_beats: got %0d want 1", nb - b0); else passed++;
        checks++; if (bdata[b0] !== 32'hA5A5_A5A5) $display("FAIL len0_data: got %h want a5a5a5a5", bdata[b0]); else passed++;
        checks++; if (blast[b0] !== 1'b1) $display("FAIL len0_rlast: got %b want 1", blast[b0]); else passed++;
        checks++; if (bresp[b0] !== 2'b00) $display("FAIL len0_rresp: got %b want 00", bresp[b0]); else passed++;
        checks++; if (bid[b0] !== 4'd2) $display("FAIL len0_rid: got %h want 2", bid[b0]); else passed++;
        checks++; if (np - p0 !== 1) $display("FAIL len0_pops: got %0d want 1", np - p0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL len0_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w [4];
        int b0, p0;
        exp_w = '{32'h3333_0001, 32'h3333_0002, 32'h3333_0003, 32'h3333_0004};
        flush();
        for (int k = 0; k < 4; k++) push(exp_w[k]);
        m_rready = 1'b1;
        b0 = nb; p0 = np;
        send_cmd(4'd3, 4'd3);
        tick();
        tick();
        m_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++; if (m_rvalid !== 1'b1 || m_rdata !== exp_w[1] || m_rlast !== 1'b0)
                $display("FAIL bp_hold%0d: got v%b %h l%b want v1 %h l0", i, m_rvalid, m_rdata, m_rlast, exp_w[1]); else passed++;
            checks++; if (fifo_en_read !== 1'b0) $display("FAIL bp_nopop%0d: got %b want 0", i, fifo_en_read); else passed++;
            tick();
        end
        m_rready = 1'b1;
        wait_beats(b0 + 4, 20);
        checks++; if (nb - b0 !== 4) $display("FAIL bp_beats: got %0d want 4", nb - b0); else passed++;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bdata[b0+k] !== exp_w[k] || blast[b0+k] !== (k == 3))
                $display("FAIL bp_beat%0d: got %h l%b want %h l%b", k, bdata[b0+k], blast[b0+k], exp_w[k], (k == 3)); else passed++;
        end
        checks++; if (np - p0 !== 4) $display("FAIL bp_pops: got %0d want 4", np - p0); else passed++;
    endtask

    task automatic test_fifo_gap();
        int b0, p0;
        flush();
        push(32'h4444_0001);
        m_rready = 1'b1;
        b0 = nb; p0 = np;
        send_cmd(4'd6, 4'd2);
        tick();
        sample();
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h4444_0001)
            $display("FAIL gap_beat1: got v%b %h want v1 44440001", m_rvalid, m_rdata); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            sample();
            checks++; if (m_rvalid !== 1'b0 || fifo_en_read !== 1'b0)
                $display("FAIL gap_bubble%0d: got v%b pop%b want v0 pop0", i, m_rvalid, fifo_en_read); else passed++;
        end
        tick();
        push(32'h4444_0002);
        push(32'h4444_0003);
        wait_beats(b0 + 3, 20);
        checks++; if (nb - b0 !== 3) $display("FAIL gap_beats: got %0d want 3", nb - b0); else passed++;
        checks++; if (bdata[b0+1] !== 32'h4444_0002 || bdata[b0+2] !== 32'h4444_0003)
            $display("FAIL gap_data: got %h %h want 44440002 44440003", bdata[b0+1], bdata[b0+2]); else passed++;
        checks++; if (blast[b0] !== 1'b0 || blast[b0+1] !== 1'b0 || blast[b0+2] !== 1'b1)
            $display("FAIL gap_rlast: got %b%b%b want 001", blast[b0], blast[b0+1], blast[b0+2]); else passed++;
        checks++; if (bcyc[b0+1] - bcyc[b0] !== 6) $display("FAIL gap_resume: got %0d want 6", bcyc[b0+1] - bcyc[b0]); else passed++;
        checks++; if (np - p0 !== 3) $display("FAIL gap_pops: got %0d want 3", np - p0); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        int b0, p0, b1, p1;
        flush();
        for (int k = 0; k < 8; k++) push(32'h5555_0000 + k);
        m_rready = 1'b1;
        b0 = nb;
        send_cmd(4'd7, 4'd7);
        wait_beats(b0 + 2, 20);
        tick();
        rst = 1'b1;
        #1;
        checks++; if (m_rvalid !== 1'b0 || m_rlast !== 1'b0 || busy !== 1'b0 || fifo_en_read !== 1'b0)
            $display("FAIL midrst_ctrl: got v%b l%b busy%b pop%b want all 0", m_rvalid, m_rlast, busy, fifo_en_read); else passed++;
        checks++; if (m_rdata !== 32'h0 || m_rid !== 4'h0 || m_rresp !== 2'b00)
            $display("FAIL midrst_data: got %h %h %b want 0 0 00", m_rdata, m_rid, m_rresp); else passed++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL midrst_cmd_ready: got %b want 0", cmd_ready); else passed++;
        b1 = nb; p1 = np;
        sample(); sample();
        checks++; if (nb - b0 !== 2) $display("FAIL midrst_sent: got %0d want 2", nb - b0); else passed++;
        checks++; if (nb !== b1 || np !== p1)
            $display("FAIL midrst_residual: got beats %0d pops %0d want 0 0", nb - b1, np - p1); else passed++;
        tick();
        rst = 1'b0;
        flush();
        sample();
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL midrst_release: got ready %b busy %b want 1 0", cmd_ready, busy); else passed++;
        push(32'h2222_0001);
        push(32'h2222_0002);
        b0 = nb; p0 = np;
        send_cmd(4'd9, 4'd1);
        wait_beats(b0 + 2, 20);
        checks++; if (nb - b0 !== 2) $display("FAIL post_beats: got %0d want 2", nb - b0); else passed++;
        checks++; if (bdata[b0] !== 32'h2222_0001 || bdata[b0+1] !== 32'h2222_0002)
            $display("FAIL post_data: got %h %h want 22220001 22220002", bdata[b0], bdata[b0+1]); else passed++;
        checks++; if (bid[b0] !== 4'd9 || bid[b0+1] !== 4'd9)
            $display("FAIL post_rid: got %h %h want 9 9", bid[b0], bid[b0+1]); else passed++;
        checks++; if (blast[b0] !== 1'b0 || blast[b0+1] !== 1'b1)
            $display("FAIL post_rlast: got %b%b want 01", blast[b0], blast[b0+1]); else passed++;
        checks++; if (np - p0 !== 2) $display("FAIL post_pops: got %0d want 2", np - p0); else passed++;
    endtask

`ifdef RDATA_STARVE_TIMEOUT_EN
    task automatic test_starve_timeout();
        int b0, p0;
        flush();
        push(32'h7777_0001);
        m_rready = 1'b1;
        b0 = nb; p0 = np;
        send_cmd(4'd4, 4'd3);
        wait_beats(b0 + 4, 60);
        checks++; if (nb - b0 !== 4) $display("FAIL starve_beats: got %0d want 4", nb - b0); else passed++;
        checks++; if (bdata[b0] !== 32'h7777_0001 || bresp[b0] !== 2'b00)
            $display("FAIL starve_beat1: got %h %b want 77770001 00", bdata[b0], bresp[b0]); else passed++;
        for (int k = 1; k < 4; k++) begin
            checks++; if (bdata[b0+k] !== 32'h0 || bresp[b0+k] !== 2'b10 || bid[b0+k] !== 4'd4)
                $display("FAIL starve_err%0d: got %h %b %h want 0 10 4", k, bdata[b0+k], bresp[b0+k], bid[b0+k]); else passed++;
            checks++; if (blast[b0+k] !== (k == 3))
                $display("FAIL starve_rlast%0d: got %b want %b", k, blast[b0+k], (k == 3)); else passed++;
        end
        checks++; if (bcyc[b0+1] - bcyc[b0] !== 11) $display("FAIL starve_delay: got %0d want 11", bcyc[b0+1] - bcyc[b0]); else passed++;
        checks++; if (np - p0 !== 1) $display("FAIL starve_pops: got %0d want 1", np - p0); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_burst4();
        test_len0();
        test_backpressure();
        test_fifo_gap();
        test_reset_mid_burst();
`ifdef RDATA_STARVE_TIMEOUT_EN
        test_starve_timeout();
`endif
        checks++; if (bad_pop !== 0) $display("FAIL pop_while_empty: got %0d want 0", bad_pop); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
